decode_stage: RTL
=================

Name: decode_stage

Overview:
- Consumes one raw x86 instruction (up to 15 bytes, little-endian byte lane order) from the fetch stage through a valid/ready handshake.
- Parses prefixes, opcode, ModR/M, SIB, displacement and immediate at one byte per cycle.
- Presents decoded fields to execute through a held-until-taken output register.
- Independently recomputes the instruction length and flags any disagreement with fetch, or any unsupported encoding, as illegal.

Parameters:
- ADDRESS_WIDTH, 32, PC width.
- MAX_INSTR_WIDTH, 120, raw instruction bus width (15 bytes).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- i_res_valid  in  1  fetch holds a valid instruction.
- i_instr  in  MAX_INSTR_WIDTH  raw bytes; byte k on [8k+7:8k].
- i_instr_len  in  4  length claimed by fetch.
- i_pc  in  ADDRESS_WIDTH  address of byte 0.
- o_dec_ready  out  1  decoder can accept; transfer on edge with i_res_valid&&o_dec_ready.
- i_flush  in  1  writeback redirect; discard all in-flight work.
- i_exec_ready  in  1  execute takes output on edge with o_valid&&i_exec_ready.
- o_valid  out  1  decoded fields valid.
- o_prefix  out  8  {lock,rep,repne,opsize,addrsize,seg_ovr,seg[1:0]}.
- o_opcode  out  8  primary opcode byte.
- o_modrm_valid  out  1  ModR/M present.
- o_mod, o_reg, o_rm  out  2/3/3  ModR/M fields.
- o_sib_valid  out  1  SIB present.
- o_scale, o_index, o_base  out  2/3/3  SIB fields.
- o_disp  out  32  sign-extended displacement.
- o_disp_size  out  3  0, 1 or 4 bytes.
- o_imm  out  32  zero-extended immediate.
- o_imm_size  out  3  0, 1, 2 or 4 bytes.
- o_len  out  4  decoder-computed length.
- o_pc  out  ADDRESS_WIDTH  instruction address.
- o_next_pc  out  ADDRESS_WIDTH  o_pc+o_len, modulo 2^ADDRESS_WIDTH.
- o_illegal  out  1  unsupported encoding or o_len != i_instr_len.

Behaviour:
- Reset (async, while reset==0):
  - state=IDLE; o_valid=0; o_dec_ready=0.
  - All output fields 0.
  - o_dec_ready rises on the first clk edge after reset deasserts.
- States: IDLE, PREFIX, MODRM, SIB, DISP, IMM, DONE.
- Byte index idx is 4 bits; each byte-consuming state reads byte idx then increments it.
- IDLE:
  - o_dec_ready=1 only here.
  - On accept (edge E0): capture instr/len/pc, clear working regs, idx=0, go to PREFIX.
- PREFIX:
  - Prefix bytes F0,F2,F3,2E,36,3E,26,64,65,66,67: record the flag and stay. The last segment prefix wins.
  - Any other byte is the opcode:
    - 00-3F with [2:1]=00/01: go to MODRM.
    - 00-3F with [2:1]=10: go to IMM. Size is 1 if [0]=0, else 4 (2 when opsize set).
    - 00-3F with [2:1]=11, and 40-5F: go to DONE.
    - 0F, or 60-FF: set illegal, go to DONE.
  - 67 present at opcode time: set illegal, go to DONE (16-bit addressing unsupported).
- MODRM:
  - Latch mod/reg/rm.
  - rm=100 and mod!=11: go to SIB.
  - mod=01: disp 1 byte. mod=10: disp 4 bytes. mod=00,rm=101: disp 4 bytes.
  - Then go to DISP if disp>0, else IMM if imm>0, else DONE.
- SIB:
  - Latch scale/index/base.
  - mod=00 with base=101 forces disp 4 bytes.
- DISP and IMM:
  - Shift one byte per cycle into bits [8j+7:8j] until the size is reached.
  - DISP sign-extends from the top byte.
- Overflow: idx reaching 15 before parsing completes sets illegal and goes to DONE.
- DONE:
  - o_len=idx; illegal |= (idx != captured i_instr_len).
  - If !o_valid || i_exec_ready: load output regs, set o_valid=1, go to IDLE.
  - Otherwise wait in DONE with working regs held.
- Latency: an L-byte instruction accepted at E0 consumes bytes at E1..EL and loads outputs at E(L+1) with no backpressure.
- o_valid and all fields are stable until taken. Take without a new load: o_valid=0 next cycle.
- Take and DONE load on the same edge: o_valid stays 1 with the new fields.
- i_flush (synchronous, highest priority after reset):
  - Next edge: state=IDLE, o_valid=0, working regs cleared.
  - An accept coinciding with i_flush is dropped.
- Illegal instructions are still presented. Execute decides the trap.

Test Plan:
1. Add reg-reg: i_instr=..D801, len=2, pc=0x100 accepted at E0 -> o_valid after E3; opcode=01, mod=3, reg=3, rm=0, o_len=2, o_next_pc=0x102, o_illegal=0.
2. Immediate with opsize prefix: bytes 05 78 56 34 12, len=5 -> o_imm=0x12345678, o_imm_size=4, o_illegal=0. Bytes 66 05 34 12 with i_instr_len=6 -> o_prefix opsize=1, o_imm=0x1234, o_imm_size=2, o_len=4, o_illegal=1.
3. SIB with disp8: bytes 03 44 8D 10, len=4 -> mod=1, rm=4, scale=2, index=1, base=5, o_disp=0x10, o_disp_size=1. Bytes 03 44 8D F0 -> o_disp=0xFFFFFFF0.
4. Backpressure: i_exec_ready=0; send 40 then 48 (len 1 each) -> first held on output, second waits in DONE, o_dec_ready=0. Raise i_exec_ready for one cycle -> o_valid stays 1 with opcode=48, then o_dec_ready=1.
5. Illegal encodings: bytes 0F A2 -> o_illegal=1, o_len=1. 15 bytes of F3 -> o_illegal=1, o_len=15.
6. Flush and reset: i_flush during the DISP state of 03 84 ... (disp32) -> next cycle state IDLE, o_valid=0, the instruction is never presented. Async reset low mid-IMM -> o_valid and o_dec_ready drop without waiting for a clock edge.

Source files
------------

// File: rtl/decode_stage.sv
// Byte-serial x86 decode stage: walks prefixes, opcode, ModR/M, SIB, displacement and
// immediate one byte per cycle, then presents the fields through a held output register.
module decode_stage #(
    parameter int unsigned ADDRESS_WIDTH   = 32,
    parameter int unsigned MAX_INSTR_WIDTH = 120
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_res_valid,
    input  logic [MAX_INSTR_WIDTH-1:0] i_instr,
    input  logic [3:0]                 i_instr_len,
    input  logic [ADDRESS_WIDTH-1:0]   i_pc,
    output logic                       o_dec_ready,
    input  logic                       i_flush,
    input  logic                       i_exec_ready,
    output logic                       o_valid,
    output logic [7:0]                 o_prefix,
    output logic [7:0]                 o_opcode,
    output logic                       o_modrm_valid,
    output logic [1:0]                 o_mod,
    output logic [2:0]                 o_reg,
    output logic [2:0]                 o_rm,
    output logic                       o_sib_valid,
    output logic [1:0]                 o_scale,
    output logic [2:0]                 o_index,
    output logic [2:0]                 o_base,
    output logic [31:0]                o_disp,
    output logic [2:0]                 o_disp_size,
    output logic [31:0]                o_imm,
    output logic [2:0]                 o_imm_size,
    output logic [3:0]                 o_len,
    output logic [ADDRESS_WIDTH-1:0]   o_pc,
    output logic [ADDRESS_WIDTH-1:0]   o_next_pc,
    output logic                       o_illegal
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREFIX, S_MODRM, S_SIB, S_DISP, S_IMM, S_DONE
    } state_t;

    typedef struct packed {
        logic [7:0]  prefix;
        logic [7:0]  opcode;
        logic        modrm_valid;
        logic [1:0]  mod;
        logic [2:0]  reg_f;
        logic [2:0]  rm;
        logic        sib_valid;
        logic [1:0]  scale;
        logic [2:0]  index;
        logic [2:0]  base;
        logic [31:0] disp;
        logic [2:0]  disp_size;
        logic [31:0] imm;
        logic [2:0]  imm_size;
        logic        illegal;
    } fields_t;

    state_t                       state_q;
    fields_t                      w_q;
    fields_t                      out_q;
    logic [MAX_INSTR_WIDTH-1:0]   instr_q;
    logic [3:0]                   len_q;
    logic [ADDRESS_WIDTH-1:0]     pc_q;
    logic [3:0]                   idx_q;
    logic [2:0]                   cnt_q;
    logic                         valid_q;
    logic                         ready_q;
    logic [3:0]                   out_len_q;
    logic [ADDRESS_WIDTH-1:0]     out_pc_q;
    logic [ADDRESS_WIDTH-1:0]     out_next_pc_q;

    logic [7:0] cur_c;
    logic [2:0] modrm_dsz_c;
    logic [2:0] sib_dsz_c;

    // Displacement size implied by a ModR/M byte alone.
    function automatic logic [2:0] modrm_disp(input logic [7:0] m);
        if (m[7:6] == 2'b01) return 3'd1;
        if (m[7:6] == 2'b10) return 3'd4;
        if (m[7:6] == 2'b00 && m[2:0] == 3'b101) return 3'd4;
        return 3'd0;
    endfunction

    function automatic state_t tail_state(input logic [2:0] dsz, input logic [2:0] isz);
        if (dsz != 3'd0) return S_DISP;
        if (isz != 3'd0) return S_IMM;
        return S_DONE;
    endfunction

    assign cur_c       = 8'(instr_q >> {idx_q, 3'b000});
    assign modrm_dsz_c = modrm_disp(cur_c);
    assign sib_dsz_c   = (w_q.mod == 2'b00 && cur_c[2:0] == 3'b101) ? 3'd4 : w_q.disp_size;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            w_q           <= '0;
            out_q         <= '0;
            instr_q       <= '0;
            len_q         <= '0;
            pc_q          <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            valid_q       <= 1'b0;
            ready_q       <= 1'b0;
            out_len_q     <= '0;
            out_pc_q      <= '0;
            out_next_pc_q <= '0;
        end else if (i_flush) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            if (valid_q && i_exec_ready) valid_q <= 1'b0;
            ready_q <= 1'b0;
            // A parse still in progress with all 15 bytes consumed cannot be valid.
            if (state_q != S_IDLE && state_q != S_DONE && idx_q == 4'hF) begin
                w_q.illegal <= 1'b1;
                state_q     <= S_DONE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        ready_q <= 1'b1;
                        if (i_res_valid && ready_q) begin
                            instr_q <= i_instr;
                            len_q   <= i_instr_len;
                            pc_q    <= i_pc;
                            w_q     <= '0;
                            idx_q   <= '0;
                            cnt_q   <= '0;
                            ready_q <= 1'b0;
                            state_q <= S_PREFIX;
                        end
                    end
                    S_PREFIX: begin
                        idx_q <= idx_q + 4'd1;
                        case (cur_c)
                            8'hF0: w_q.prefix[7] <= 1'b1;
                            8'hF3: w_q.prefix[6] <= 1'b1;
                            8'hF2: w_q.prefix[5] <= 1'b1;
                            8'h66: w_q.prefix[4] <= 1'b1;
                            8'h67: w_q.prefix[3] <= 1'b1;
                            8'h26, 8'h2E, 8'h36, 8'h3E: w_q.prefix[2:0] <= {1'b1, cur_c[4:3]};
                            8'h64, 8'h65: w_q.prefix[2:0] <= {2'b10, cur_c[0]};
                            default: begin
                                w_q.opcode <= cur_c;
                                cnt_q      <= '0;
                                if (w_q.prefix[3] || cur_c == 8'h0F || cur_c >= 8'h60) begin
                                    w_q.illegal <= 1'b1;
                                    state_q     <= S_DONE;
                                end else if (cur_c < 8'h40) begin
                                    case (cur_c[2:1])
                                        2'b00, 2'b01: state_q <= S_MODRM;
                                        2'b10: begin
                                            w_q.imm_size <= !cur_c[0] ? 3'd1 :
                                                            (w_q.prefix[4] ? 3'd2 : 3'd4);
                                            state_q      <= S_IMM;
                                        end
                                        default: state_q <= S_DONE;
                                    endcase
                                end else begin
                                    state_q <= S_DONE;
                                end
                            end
                        endcase
                    end
                    S_MODRM: begin
                        idx_q           <= idx_q + 4'd1;
                        w_q.modrm_valid <= 1'b1;
                        w_q.mod         <= cur_c[7:6];
                        w_q.reg_f       <= cur_c[5:3];
                        w_q.rm          <= cur_c[2:0];
                        w_q.disp_size   <= modrm_dsz_c;
                        if (cur_c[2:0] == 3'b100 && cur_c[7:6] != 2'b11) state_q <= S_SIB;
                        else state_q <= tail_state(modrm_dsz_c, w_q.imm_size);
                    end
                    S_SIB: begin
                        idx_q         <= idx_q + 4'd1;
                        w_q.sib_valid <= 1'b1;
                        w_q.scale     <= cur_c[7:6];
                        w_q.index     <= cur_c[5:3];
                        w_q.base      <= cur_c[2:0];
                        w_q.disp_size <= sib_dsz_c;
                        state_q       <= tail_state(sib_dsz_c, w_q.imm_size);
                    end
                    S_DISP: begin
                        idx_q <= idx_q + 4'd1;
                        // Byte 0 seeds the sign; later bytes overwrite upward.
                        if (cnt_q == 3'd0) w_q.disp <= {{24{cur_c[7]}}, cur_c};
                        else w_q.disp[{cnt_q, 3'b000} +: 8] <= cur_c;
                        if (3'(cnt_q + 3'd1) == w_q.disp_size) begin
                            cnt_q   <= '0;
                            state_q <= tail_state(3'd0, w_q.imm_size);
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                    S_IMM: begin
                        idx_q <= idx_q + 4'd1;
                        w_q.imm[{cnt_q, 3'b000} +: 8] <= cur_c;
                        if (3'(cnt_q + 3'd1) == w_q.imm_size) begin
                            cnt_q   <= '0;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                    S_DONE: begin
                        if (!valid_q || i_exec_ready) begin
                            out_q         <= w_q;
                            out_q.illegal <= w_q.illegal | (idx_q != len_q);
                            out_len_q     <= idx_q;
                            out_pc_q      <= pc_q;
                            out_next_pc_q <= pc_q + ADDRESS_WIDTH'(idx_q);
                            valid_q       <= 1'b1;
                            ready_q       <= 1'b1;
                            state_q       <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign o_dec_ready   = ready_q;
    assign o_valid       = valid_q;
    assign o_prefix      = out_q.prefix;
    assign o_opcode      = out_q.opcode;
    assign o_modrm_valid = out_q.modrm_valid;
    assign o_mod         = out_q.mod;
    assign o_reg         = out_q.reg_f;
    assign o_rm          = out_q.rm;
    assign o_sib_valid   = out_q.sib_valid;
    assign o_scale       = out_q.scale;
    assign o_index       = out_q.index;
    assign o_base        = out_q.base;
    assign o_disp        = out_q.disp;
    assign o_disp_size   = out_q.disp_size;
    assign o_imm         = out_q.imm;
    assign o_imm_size    = out_q.imm_size;
    assign o_illegal     = out_q.illegal;
    assign o_len         = out_len_q;
    assign o_pc          = out_pc_q;
    assign o_next_pc     = out_next_pc_q;

endmodule
